run_controller: RTL and testbench
=================================

// Module: run_controller
// PURPOSE
// Execution sequencer for the single-cycle MIPS system. Gates the datapath with a clock-enable and supports run/halt/single-step, PC load and one PC breakpoint.
// Also captures the exception PC and cause, with optional auto-vectoring to a handler.
// Sits between the board buttons and the PC/REG/DMEM write enables plus the PC_in_real load mux.
// PARAMETERS
// PC_W        8       PC width (byte address)
// CNT_W       16      width of executed-cycle counter
// AUTO_VEC    0       1: on exception load EXC_VECTOR and resume; 0: park in EXC
// EXC_VECTOR  8'h80   handler address used when AUTO_VEC=1
// PORTS
// SYS_clk      in   1      system clock, rising edge
// SYS_reset    in   1      asynchronous, active-high reset
// RC_run       in   1      run button (level; rising edge acts)
// RC_halt      in   1      halt button (level; rising edge acts)
// RC_step      in   1      single-step button (level; rising edge acts)
// RC_load      in   1      load button (level; rising edge acts)
// RC_load_val  in   PC_W   PC value sampled on RC_load edge
// RC_pc        in   PC_W   current PC from datapath
// RC_bp_en     in   1      breakpoint enable
// RC_bp_addr   in   PC_W   breakpoint PC
// RC_exc_in    in   1      datapath exception (valid only while RC_cpu_en=1)
// RC_exc_code  in   2      cause: 1 overflow, 2 undefined op, 3 arith other
// RC_cpu_en    out  1      datapath state-update enable
// RC_pc_load   out  1      force PC <= RC_pc_val next edge
// RC_pc_val    out  PC_W   value to load
// RC_epc       out  PC_W   PC of faulting instruction
// RC_cause     out  2      latched cause, 0 = none
// RC_state     out  3      current FSM state
// RC_cycles    out  CNT_W  cycles with RC_cpu_en=1, saturating
// BEHAVIOUR
// - Reset: state HALT; all outputs 0; edge-history regs = 1 (buttons held through reset give no edge).
// - Edges: registered rising edge per button. Priority when simultaneous: halt > load > step > run.
// - States: HALT=0, RUN=1, STEP=2, LOAD=3, EXC=4; others -> HALT.
// - HALT: cpu_en=0. load->LOAD, step->STEP, run->RUN.
// - RUN: cpu_en=1 except on breakpoint hit (bp_en && RC_pc==bp_addr && !bp_skip).
//   - Hit: cpu_en=0 that cycle (combinational), next HALT.
//   - halt edge: next HALT; the current cycle still executes.
// - bp_skip: set on any entry to RUN/STEP from HALT, cleared after first enabled cycle, so resume at the bp PC executes it.
// - STEP: cpu_en=1 for exactly one cycle, then HALT; breakpoint ignored.
// - LOAD: cpu_en=0, pc_load=1, pc_val=sampled load_val, RC_cycles cleared, RC_cause cleared; 1 cycle -> HALT.
// - Exception: RC_exc_in && cpu_en in RUN/STEP latches RC_epc<=RC_pc and RC_cause<=exc_code; next EXC.
//   - Exception takes priority over halt edge and breakpoint in the same cycle.
// - EXC, AUTO_VEC=1: one cycle with pc_load=1, pc_val=EXC_VECTOR, cpu_en=0; then RUN. epc/cause held.
// - EXC, AUTO_VEC=0: cpu_en=0, stays until load edge -> LOAD. Other buttons ignored.
// - RC_cycles: +1 each cycle cpu_en=1; saturates at all-ones; no wrap.
// - pc_load and cpu_en never both 1.
// - Reset mid-operation: immediate return to reset values, no pending button state retained.
// STRUCTURE
// - Package rc_pkg: state encodings (RC_HALT..RC_EXC), cause codes, state width.
// - Sub-module rc_edge_detect: one instance per button, async reset to 1, 1-bit rising-edge pulse out.
// - Top: FSM register plus registered epc/cause/cycles/load_val/bp_skip; cpu_en and pc_load combinational from state.
// TESTING
// 1 Reset with RC_run held high, release reset -> state HALT, cpu_en=0, no RUN until run re-pressed.
// 2 load edge val=8'h10, then 3 step edges -> pc_load=1 with 8'h10 for 1 cycle; 3 single-cycle cpu_en pulses; RC_cycles=3.
// 3 bp_en=1, bp_addr=8'h0C, run from PC 0 -> halt with cpu_en=0 at PC 0C; run again -> 0C executes, RC_cycles=4.
// 4 RUN, exc_in=1 code=1 at PC 8'h14, AUTO_VEC=0 -> epc=8'h14, cause=1, state EXC; run/step ignored; load exits.
// 5 AUTO_VEC=1, EXC_VECTOR=8'h80, exception at 8'h20 -> one pc_load cycle with 8'h80, then RUN; epc=8'h20.
// 6 halt+run edges in same cycle while RUN -> HALT; CNT_W=4, run 20 cycles -> RC_cycles=4'hF held.

Source files
------------

// File: rtl/run_controller_pkg.sv
// Shared encodings for the run controller: FSM state values and exception cause codes.
package rc_pkg;

  localparam int RC_STATE_W = 3;

  typedef enum logic [RC_STATE_W-1:0] {
    RC_HALT = 3'd0,
    RC_RUN  = 3'd1,
    RC_STEP = 3'd2,
    RC_LOAD = 3'd3,
    RC_EXC  = 3'd4
  } rc_state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_OVF   = 2'd1;
  localparam logic [1:0] CAUSE_UNDEF = 2'd2;
  localparam logic [1:0] CAUSE_ARITH = 2'd3;

endpackage

// File: rtl/run_controller_if.sv
// Buttons/datapath to run controller bundle; master drives buttons and datapath status, slave is the controller.
interface run_controller_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  import rc_pkg::*;

  logic                  RC_run;
  logic                  RC_halt;
  logic                  RC_step;
  logic                  RC_load;
  logic [PC_W-1:0]       RC_load_val;
  logic [PC_W-1:0]       RC_pc;
  logic                  RC_bp_en;
  logic [PC_W-1:0]       RC_bp_addr;
  logic                  RC_exc_in;
  logic [1:0]            RC_exc_code;
  logic                  RC_cpu_en;
  logic                  RC_pc_load;
  logic [PC_W-1:0]       RC_pc_val;
  logic [PC_W-1:0]       RC_epc;
  logic [1:0]            RC_cause;
  logic [RC_STATE_W-1:0] RC_state;
  logic [CNT_W-1:0]      RC_cycles;

  modport master (
    output RC_run, RC_halt, RC_step, RC_load, RC_load_val, RC_pc,
           RC_bp_en, RC_bp_addr, RC_exc_in, RC_exc_code,
    input  RC_cpu_en, RC_pc_load, RC_pc_val, RC_epc, RC_cause, RC_state, RC_cycles
  );

  modport slave (
    input  RC_run, RC_halt, RC_step, RC_load, RC_load_val, RC_pc,
           RC_bp_en, RC_bp_addr, RC_exc_in, RC_exc_code,
    output RC_cpu_en, RC_pc_load, RC_pc_val, RC_epc, RC_cause, RC_state, RC_cycles
  );

endinterface

// File: rtl/rc_edge_detect.sv
// Rising-edge detector for a level button; history resets high so a button held through reset gives no pulse.
module rc_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= btn;
  end

  assign pulse = btn & ~prev;

endmodule

// File: rtl/run_controller.sv
// Execution sequencer for the single-cycle MIPS: run/halt/step/load, one PC breakpoint,
// exception capture with optional auto-vectoring, and a saturating executed-cycle counter.
module run_controller
  import rc_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter int              CNT_W      = 16,
  parameter bit              AUTO_VEC   = 1'b0,
  parameter logic [PC_W-1:0] EXC_VECTOR = 'h80
) (
  input logic           SYS_clk,
  input logic           SYS_reset,
  run_controller_if.slave bus
);

  logic             run_edge, halt_edge, step_edge, load_edge;
  rc_state_e        state;
  logic [PC_W-1:0]  epc, load_val_q, pc_val;
  logic [1:0]       cause;
  logic [CNT_W-1:0] cycles;
  logic             bp_skip, bp_hit, cpu_en, pc_load, exc_take;

  rc_edge_detect u_run  (.clk(SYS_clk), .rst(SYS_reset), .btn(bus.RC_run),  .pulse(run_edge));
  rc_edge_detect u_halt (.clk(SYS_clk), .rst(SYS_reset), .btn(bus.RC_halt), .pulse(halt_edge));
  rc_edge_detect u_step (.clk(SYS_clk), .rst(SYS_reset), .btn(bus.RC_step), .pulse(step_edge));
  rc_edge_detect u_load (.clk(SYS_clk), .rst(SYS_reset), .btn(bus.RC_load), .pulse(load_edge));

  // bp_skip lets a resume at the breakpoint PC execute it instead of re-halting.
  always_comb begin
    bp_hit   = bus.RC_bp_en && (bus.RC_pc == bus.RC_bp_addr) && !bp_skip;
    cpu_en   = ((state == RC_RUN) && !bp_hit) || (state == RC_STEP);
    pc_load  = (state == RC_LOAD) || (AUTO_VEC && (state == RC_EXC));
    exc_take = bus.RC_exc_in && cpu_en;
    pc_val   = '0;
    if (state == RC_LOAD)                   pc_val = load_val_q;
    else if (AUTO_VEC && (state == RC_EXC)) pc_val = EXC_VECTOR;
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state      <= RC_HALT;
      epc        <= '0;
      cause      <= CAUSE_NONE;
      cycles     <= '0;
      load_val_q <= '0;
      bp_skip    <= 1'b0;
    end else begin
      if (cpu_en) begin
        bp_skip <= 1'b0;
        if (cycles != {CNT_W{1'b1}}) cycles <= cycles + 1'b1;
      end
      if (exc_take) begin
        epc   <= bus.RC_pc;
        cause <= bus.RC_exc_code;
      end
      case (state)
        RC_HALT: begin
          if (halt_edge) begin
            state <= RC_HALT;
          end else if (load_edge) begin
            state      <= RC_LOAD;
            load_val_q <= bus.RC_load_val;
          end else if (step_edge) begin
            state   <= RC_STEP;
            bp_skip <= 1'b1;
          end else if (run_edge) begin
            state   <= RC_RUN;
            bp_skip <= 1'b1;
          end
        end
        RC_RUN: begin
          if (exc_take)                state <= RC_EXC;
          else if (halt_edge || bp_hit) state <= RC_HALT;
        end
        RC_STEP: begin
          state <= exc_take ? RC_EXC : RC_HALT;
        end
        RC_LOAD: begin
          cycles <= '0;
          cause  <= CAUSE_NONE;
          state  <= RC_HALT;
        end
        RC_EXC: begin
          // Parked unless auto-vectoring; only a load edge leaves a parked exception.
          if (AUTO_VEC) begin
            state <= RC_RUN;
          end else if (load_edge) begin
            state      <= RC_LOAD;
            load_val_q <= bus.RC_load_val;
          end
        end
        default: state <= RC_HALT;
      endcase
    end
  end

  assign bus.RC_cpu_en  = cpu_en;
  assign bus.RC_pc_load = pc_load;
  assign bus.RC_pc_val  = pc_val;
  assign bus.RC_epc     = epc;
  assign bus.RC_cause   = cause;
  assign bus.RC_state   = state;
  assign bus.RC_cycles  = cycles;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench: table of directed vectors on the default controller plus
// hand sequences for auto-vectoring and counter saturation.
module tb_run_controller;
  import rc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  run_controller_if #(.PC_W(8), .CNT_W(16)) bus0 ();
  run_controller_if #(.PC_W(8), .CNT_W(16)) bus1 ();
  run_controller_if #(.PC_W(8), .CNT_W(4))  bus2 ();

  run_controller #(.PC_W(8), .CNT_W(16), .AUTO_VEC(1'b0), .EXC_VECTOR(8'h80))
    dut0 (.SYS_clk(clk), .SYS_reset(rst), .bus(bus0));
  run_controller #(.PC_W(8), .CNT_W(16), .AUTO_VEC(1'b1), .EXC_VECTOR(8'h80))
    dut1 (.SYS_clk(clk), .SYS_reset(rst), .bus(bus1));
  run_controller #(.PC_W(8), .CNT_W(4), .AUTO_VEC(1'b0), .EXC_VECTOR(8'h80))
    dut2 (.SYS_clk(clk), .SYS_reset(rst), .bus(bus2));

  // Minimal datapath PC: load wins, otherwise advance one word per enabled cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus0.RC_pc <= '0;
      bus1.RC_pc <= '0;
      bus2.RC_pc <= '0;
    end else begin
      if (bus0.RC_pc_load)     bus0.RC_pc <= bus0.RC_pc_val;
      else if (bus0.RC_cpu_en) bus0.RC_pc <= bus0.RC_pc + 8'd4;
      if (bus1.RC_pc_load)     bus1.RC_pc <= bus1.RC_pc_val;
      else if (bus1.RC_cpu_en) bus1.RC_pc <= bus1.RC_pc + 8'd4;
      if (bus2.RC_pc_load)     bus2.RC_pc <= bus2.RC_pc_val;
      else if (bus2.RC_cpu_en) bus2.RC_pc <= bus2.RC_pc + 8'd4;
    end
  end

  typedef struct {
    logic [3:0]  btn;
    logic [7:0]  loadVal;
    logic        bpEn;
    logic [7:0]  bpAddr;
    logic        excIn;
    logic [1:0]  excCode;
    logic [2:0]  expState;
    logic        expCpuEn;
    logic        expPcLoad;
    logic [7:0]  expPcVal;
    logic [15:0] expCycles;
    logic [1:0]  expCause;
    logic [7:0]  expEpc;
  } vec_t;

  vec_t vecs[34];

  // btn packs {halt, load, step, run}.
  function automatic vec_t mk(input logic [3:0] btn, input logic [7:0] lv, input logic bpe,
                              input logic [7:0] bpa, input logic exc, input logic [1:0] code,
                              input logic [2:0] st, input logic ce, input logic pl,
                              input logic [7:0] pv, input logic [15:0] cyc,
                              input logic [1:0] cs, input logic [7:0] ep);
    vec_t v;
    v.btn = btn;  v.loadVal = lv;  v.bpEn = bpe;  v.bpAddr = bpa;
    v.excIn = exc;  v.excCode = code;  v.expState = st;  v.expCpuEn = ce;
    v.expPcLoad = pl;  v.expPcVal = pv;  v.expCycles = cyc;  v.expCause = cs;
    v.expEpc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus0.RC_halt     = v.btn[3];
    bus0.RC_load     = v.btn[2];
    bus0.RC_step     = v.btn[1];
    bus0.RC_run      = v.btn[0];
    bus0.RC_load_val = v.loadVal;
    bus0.RC_bp_en    = v.bpEn;
    bus0.RC_bp_addr  = v.bpAddr;
    bus0.RC_exc_in   = v.excIn;
    bus0.RC_exc_code = v.excCode;
  endtask

  initial begin
    vecs[0]  = mk(4'b0100, 8'h10, 0, 8'h00, 0, 0, RC_LOAD, 0, 1, 8'h10, 0, 0, 8'h00);
    vecs[1]  = mk(4'b0000, 8'h10, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 0, 0, 8'h00);
    vecs[2]  = mk(4'b0010, 8'h00, 0, 8'h00, 0, 0, RC_STEP, 1, 0, 8'h00, 0, 0, 8'h00);
    vecs[3]  = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 1, 0, 8'h00);
    vecs[4]  = mk(4'b0010, 8'h00, 0, 8'h00, 0, 0, RC_STEP, 1, 0, 8'h00, 1, 0, 8'h00);
    vecs[5]  = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 2, 0, 8'h00);
    vecs[6]  = mk(4'b0010, 8'h00, 0, 8'h00, 0, 0, RC_STEP, 1, 0, 8'h00, 2, 0, 8'h00);
    vecs[7]  = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 3, 0, 8'h00);
    vecs[8]  = mk(4'b0100, 8'h00, 0, 8'h00, 0, 0, RC_LOAD, 0, 1, 8'h00, 3, 0, 8'h00);
    vecs[9]  = mk(4'b0000, 8'h00, 1, 8'h0C, 0, 0, RC_HALT, 0, 0, 8'h00, 0, 0, 8'h00);
    vecs[10] = mk(4'b0001, 8'h00, 1, 8'h0C, 0, 0, RC_RUN,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[11] = mk(4'b0000, 8'h00, 1, 8'h0C, 0, 0, RC_RUN,  1, 0, 8'h00, 1, 0, 8'h00);
    vecs[12] = mk(4'b0000, 8'h00, 1, 8'h0C, 0, 0, RC_RUN,  1, 0, 8'h00, 2, 0, 8'h00);
    vecs[13] = mk(4'b0000, 8'h00, 1, 8'h0C, 0, 0, RC_RUN,  0, 0, 8'h00, 3, 0, 8'h00);
    vecs[14] = mk(4'b0000, 8'h00, 1, 8'h0C, 0, 0, RC_HALT, 0, 0, 8'h00, 3, 0, 8'h00);
    vecs[15] = mk(4'b0001, 8'h00, 1, 8'h0C, 0, 0, RC_RUN,  1, 0, 8'h00, 3, 0, 8'h00);
    vecs[16] = mk(4'b0000, 8'h00, 1, 8'h0C, 0, 0, RC_RUN,  1, 0, 8'h00, 4, 0, 8'h00);
    vecs[17] = mk(4'b1000, 8'h00, 1, 8'h0C, 0, 0, RC_HALT, 0, 0, 8'h00, 5, 0, 8'h00);
    vecs[18] = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 5, 0, 8'h00);
    vecs[19] = mk(4'b0001, 8'h00, 0, 8'h00, 0, 0, RC_RUN,  1, 0, 8'h00, 5, 0, 8'h00);
    vecs[20] = mk(4'b0000, 8'h00, 0, 8'h00, 1, 1, RC_EXC,  0, 0, 8'h00, 6, 1, 8'h14);
    vecs[21] = mk(4'b0001, 8'h00, 0, 8'h00, 0, 0, RC_EXC,  0, 0, 8'h00, 6, 1, 8'h14);
    vecs[22] = mk(4'b0010, 8'h00, 0, 8'h00, 0, 0, RC_EXC,  0, 0, 8'h00, 6, 1, 8'h14);
    vecs[23] = mk(4'b1000, 8'h00, 0, 8'h00, 0, 0, RC_EXC,  0, 0, 8'h00, 6, 1, 8'h14);
    vecs[24] = mk(4'b0100, 8'h40, 0, 8'h00, 0, 0, RC_LOAD, 0, 1, 8'h40, 6, 1, 8'h14);
    vecs[25] = mk(4'b0000, 8'h40, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 0, 0, 8'h14);
    vecs[26] = mk(4'b0011, 8'h00, 0, 8'h00, 0, 0, RC_STEP, 1, 0, 8'h00, 0, 0, 8'h14);
    vecs[27] = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 1, 0, 8'h14);
    vecs[28] = mk(4'b1111, 8'h50, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 1, 0, 8'h14);
    vecs[29] = mk(4'b0000, 8'h50, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 1, 0, 8'h14);
    vecs[30] = mk(4'b0111, 8'h50, 0, 8'h00, 0, 0, RC_LOAD, 0, 1, 8'h50, 1, 0, 8'h14);
    vecs[31] = mk(4'b0000, 8'h50, 0, 8'h00, 0, 0, RC_HALT, 0, 0, 8'h00, 0, 0, 8'h14);
    vecs[32] = mk(4'b0010, 8'h00, 0, 8'h00, 0, 0, RC_STEP, 1, 0, 8'h00, 0, 0, 8'h14);
    vecs[33] = mk(4'b0000, 8'h00, 0, 8'h00, 1, 2, RC_EXC,  0, 0, 8'h00, 1, 2, 8'h50);

    applyStimulus(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    {bus1.RC_run, bus1.RC_halt, bus1.RC_step, bus1.RC_load} = 4'b0000;
    {bus2.RC_run, bus2.RC_halt, bus2.RC_step, bus2.RC_load} = 4'b0000;
    bus1.RC_load_val = '0; bus1.RC_bp_en = 0; bus1.RC_bp_addr = '0;
    bus1.RC_exc_in = 0; bus1.RC_exc_code = '0;
    bus2.RC_load_val = '0; bus2.RC_bp_en = 0; bus2.RC_bp_addr = '0;
    bus2.RC_exc_in = 0; bus2.RC_exc_code = '0;

    // Run held through reset must not start the CPU.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_state", bus0.RC_state, RC_HALT);
    checkOutput("rst_cpu_en", bus0.RC_cpu_en, 0);
    checkOutput("rst_pc_load", bus0.RC_pc_load, 0);
    checkOutput("rst_cycles", bus0.RC_cycles, 0);
    checkOutput("rst_cause", bus0.RC_cause, 0);
    bus0.RC_run = 1'b0;
    tick();
    checkOutput("rst_release_state", bus0.RC_state, RC_HALT);

    for (int i = 0; i < 34; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_state", i), bus0.RC_state, vecs[i].expState);
      checkOutput($sformatf("v%0d_cpu_en", i), bus0.RC_cpu_en, vecs[i].expCpuEn);
      checkOutput($sformatf("v%0d_pc_load", i), bus0.RC_pc_load, vecs[i].expPcLoad);
      checkOutput($sformatf("v%0d_pc_val", i), bus0.RC_pc_val, vecs[i].expPcVal);
      checkOutput($sformatf("v%0d_cycles", i), bus0.RC_cycles, vecs[i].expCycles);
      checkOutput($sformatf("v%0d_cause", i), bus0.RC_cause, vecs[i].expCause);
      checkOutput($sformatf("v%0d_epc", i), bus0.RC_epc, vecs[i].expEpc);
    end
    applyStimulus(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset while parked in EXC.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_state", bus0.RC_state, RC_HALT);
    checkOutput("midrst_cause", bus0.RC_cause, 0);
    checkOutput("midrst_epc", bus0.RC_epc, 0);
    checkOutput("midrst_cycles", bus0.RC_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Auto-vectoring controller.
    bus1.RC_load = 1'b1; bus1.RC_load_val = 8'h20;
    tick();
    bus1.RC_load = 1'b0;
    tick();
    bus1.RC_run = 1'b1;
    tick();
    checkOutput("av_run_cpu_en", bus1.RC_cpu_en, 1);
    bus1.RC_run = 1'b0; bus1.RC_exc_in = 1'b1; bus1.RC_exc_code = 2'd3;
    tick();
    bus1.RC_exc_in = 1'b0;
    checkOutput("av_exc_state", bus1.RC_state, RC_EXC);
    checkOutput("av_exc_pc_load", bus1.RC_pc_load, 1);
    checkOutput("av_exc_pc_val", bus1.RC_pc_val, 8'h80);
    checkOutput("av_exc_cpu_en", bus1.RC_cpu_en, 0);
    checkOutput("av_exc_epc", bus1.RC_epc, 8'h20);
    checkOutput("av_exc_cause", bus1.RC_cause, 3);
    tick();
    checkOutput("av_resume_state", bus1.RC_state, RC_RUN);
    checkOutput("av_resume_pc_load", bus1.RC_pc_load, 0);
    checkOutput("av_resume_cpu_en", bus1.RC_cpu_en, 1);
    checkOutput("av_resume_epc", bus1.RC_epc, 8'h20);
    checkOutput("av_resume_cause", bus1.RC_cause, 3);

    // Halt beats run in the same cycle; narrow counter saturates.
    bus2.RC_run = 1'b1;
    tick();
    bus2.RC_run = 1'b0;
    tick();
    bus2.RC_halt = 1'b1; bus2.RC_run = 1'b1;
    tick();
    checkOutput("sat_halt_state", bus2.RC_state, RC_HALT);
    checkOutput("sat_halt_cycles", bus2.RC_cycles, 2);
    bus2.RC_halt = 1'b0; bus2.RC_run = 1'b0;
    tick();
    bus2.RC_run = 1'b1;
    tick();
    bus2.RC_run = 1'b0;
    repeat (12) tick();
    checkOutput("sat_pre_cycles", bus2.RC_cycles, 4'hE);
    repeat (8) tick();
    checkOutput("sat_cycles", bus2.RC_cycles, 4'hF);
    checkOutput("sat_state", bus2.RC_state, RC_RUN);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
